// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1:N serial-to-parallel demux.
package demux_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_OUT_DEF = 8;

  // Destination bit of y for the sel-th accepted bit of a frame.
  function automatic int slot_idx(input int sel, input logic msb_first, input int n_out);
    if (msb_first) begin
      return n_out - 1 - sel;
    end else begin
      return sel;
    end
  endfunction

  // Even parity over a word of up to 16 bits, zero-extended by the caller.
  function automatic logic word_parity(input logic [15:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/demux_idx_ctr.sv
// Slot index counter: clear has priority over increment, wraps after N_OUT-1.
module demux_idx_ctr #(
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [SEL_W-1:0] sel,
  output logic             tc
);

  logic [SEL_W-1:0] sel_r;
  logic             tc_s;

  assign tc_s = (sel_r == SEL_W'(N_OUT - 1));

  // Index register with synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r <= '0;
    end else if (clr) begin
      sel_r <= '0;
    end else if (inc) begin
      sel_r <= tc_s ? '0 : (sel_r + SEL_W'(1));
    end else begin
      sel_r <= sel_r;
    end
  end

  assign sel = sel_r;
  assign tc  = tc_s;

endmodule

// File: rtl/demux_1_8_sipo.sv
// 1:N sequential demux / serial-to-parallel converter with a valid/ready frame port.
// Optional frame parity output enabled by defining DEMUX_PARITY_EN.
module demux_1_8_sipo
  import demux_pkg::*;
#(
  parameter int N_OUT     = N_OUT_DEF,
  parameter int SEL_W     = $clog2(N_OUT),
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             din_valid,
  input  logic             din,
  output logic             din_ready,
  output logic [N_OUT-1:0] y,
  output logic [SEL_W-1:0] sel,
  output logic             frame_valid,
`ifdef DEMUX_PARITY_EN
  output logic             frame_par,
`endif
  input  logic             frame_ready
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [N_OUT-1:0] y_r;
  logic [N_OUT-1:0] y_nxt_s;
  logic [SEL_W-1:0] sel_s;
  logic             tc_s;
  logic             din_ready_s;
  logic             accept_s;
  logic             frame_valid_r;
  int               slot_s;

  assign din_ready_s = (state_r == FILL);
  assign accept_s    = din_valid & din_ready_s;
  assign slot_s      = slot_idx(int'(sel_s), (MSB_FIRST != 0), N_OUT);

  demux_idx_ctr #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_idx_ctr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (accept_s),
    .sel (sel_s),
    .tc  (tc_s)
  );

  // State register; flush forces the frame back to FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
    end else if (flush) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && tc_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FILL;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // Steer the accepted bit into its slot; other slots keep their old value.
  always_comb begin
    y_nxt_s = y_r;
    for (int i = 0; i < N_OUT; i++) begin
      if (accept_s && (slot_s == i)) begin
        y_nxt_s[i] = din;
      end else begin
        y_nxt_s[i] = y_r[i];
      end
    end
  end

  // Word and frame-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r           <= '0;
      frame_valid_r <= 1'b0;
    end else if (flush) begin
      y_r           <= '0;
      frame_valid_r <= 1'b0;
    end else begin
      y_r           <= y_nxt_s;
      frame_valid_r <= (state_nxt_s == HOLD);
    end
  end

`ifdef DEMUX_PARITY_EN
  logic frame_par_r;

  // Parity captured on the edge that completes the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_par_r <= 1'b0;
    end else if (flush) begin
      frame_par_r <= 1'b0;
    end else if ((state_r == FILL) && (state_nxt_s == HOLD)) begin
      frame_par_r <= word_parity(16'(y_nxt_s));
    end else begin
      frame_par_r <= frame_par_r;
    end
  end

  assign frame_par = frame_par_r;
`endif

  assign din_ready   = din_ready_s;
  assign y           = y_r;
  assign sel         = sel_s;
  assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_demux_1_8_sipo.sv
// Directed bench for demux_1_8_sipo: an LSB-first and an MSB-first instance share one stimulus stream.
module tb_demux_1_8_sipo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       din_valid;
  logic       din;
  logic       frame_ready;

  logic       din_ready_l, din_ready_m;
  logic [7:0] y_l, y_m;
  logic [2:0] sel_l, sel_m;
  logic       fv_l, fv_m;
`ifdef DEMUX_PARITY_EN
  logic       par_l, par_m;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux_1_8_sipo #(.N_OUT(8), .MSB_FIRST(0)) u_lsb (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready_l),
    .y           (y_l),
    .sel         (sel_l),
    .frame_valid (fv_l),
`ifdef DEMUX_PARITY_EN
    .frame_par   (par_l),
`endif
    .frame_ready (frame_ready)
  );

  demux_1_8_sipo #(.N_OUT(8), .MSB_FIRST(1)) u_msb (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready_m),
    .y           (y_m),
    .sel         (sel_m),
    .frame_valid (fv_m),
`ifdef DEMUX_PARITY_EN
    .frame_par   (par_m),
`endif
    .frame_ready (frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
  endtask

  logic [7:0] pat;
  int         fv_count;

  initial begin
    rst = 1'b1; flush = 1'b0; din_valid = 1'b1; din = 1'b1; frame_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_y",     32'(y_l), 32'h00);
    check_eq("rst_y_msb", 32'(y_m), 32'h00);
    check_eq("rst_sel",   32'(sel_l), 32'd0);
    check_eq("rst_fv",    32'(fv_l), 32'd0);
    check_eq("rst_rdy",   32'(din_ready_l), 32'd1);
    din_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("idle_sel", 32'(sel_l), 32'd0);

    // LSB-first frame 1,0,1,0,0,0,1,0 -> 0x45 (MSB-first instance 0xA2)
    pat = 8'h45;
    for (int i = 0; i < 7; i++) send_bit(pat[i]);
    check_eq("part_sel", 32'(sel_l), 32'd7);
    check_eq("part_fv",  32'(fv_l), 32'd0);
    send_bit(pat[7]);
    check_eq("f1_fv",    32'(fv_l), 32'd1);
    check_eq("f1_y",     32'(y_l), 32'h45);
    check_eq("f1_y_msb", 32'(y_m), 32'hA2);
    check_eq("f1_rdy",   32'(din_ready_l), 32'd0);
    check_eq("f1_sel",   32'(sel_l), 32'd0);
    din_valid = 1'b1; din = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    din_valid = 1'b0;
    check_eq("hold_y",   32'(y_l), 32'h45);
    check_eq("hold_fv",  32'(fv_l), 32'd1);
    check_eq("hold_sel", 32'(sel_l), 32'd0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check_eq("rel_fv",  32'(fv_l), 32'd0);
    check_eq("rel_rdy", 32'(din_ready_l), 32'd1);
    check_eq("rel_y",   32'(y_l), 32'h45);

    // Gapped input: sel moves only on accepts; 0x1D LSB-first, 0xB8 MSB-first
    pat = 8'h1D;
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1; din = pat[i];
      tick();
      check_eq("gap_sel_acc", 32'(sel_l), 32'((i + 1) % 8));
      din_valid = 1'b0; din = ~pat[i];
      tick();
      check_eq("gap_sel_idle", 32'(sel_l), 32'((i + 1) % 8));
    end
    check_eq("gap_y",     32'(y_l), 32'h1D);
    check_eq("gap_y_msb", 32'(y_m), 32'hB8);
    check_eq("gap_fv",    32'(fv_l), 32'd1);
    din_valid = 1'b1; din = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    din_valid = 1'b0;
    check_eq("bp_y",   32'(y_l), 32'h1D);
    check_eq("bp_sel", 32'(sel_l), 32'd0);
    check_eq("bp_fv",  32'(fv_l), 32'd1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;

    // Flush after 3 accepts, with a concurrent bit offered
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check_eq("pre_fl_sel", 32'(sel_l), 32'd3);
    check_eq("pre_fl_y",   32'(y_l), 32'h1F);
    flush = 1'b1; din_valid = 1'b1; din = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    check_eq("fl_sel", 32'(sel_l), 32'd0);
    check_eq("fl_y",   32'(y_l), 32'h00);
    check_eq("fl_fv",  32'(fv_l), 32'd0);
    pat = 8'h45;
    for (int i = 0; i < 8; i++) send_bit(pat[i]);
    check_eq("post_fl_y",     32'(y_l), 32'h45);
    check_eq("post_fl_y_msb", 32'(y_m), 32'hA2);
    check_eq("post_fl_fv",    32'(fv_l), 32'd1);
`ifdef DEMUX_PARITY_EN
    check_eq("par_45", 32'(par_l), 32'd1);
`endif
    frame_ready = 1'b1;
    tick();

    // Back-to-back frames 0xFF then 0x00 with frame_ready tied high
    fv_count = 0;
    din_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      din = (c <= 9) ? 1'b1 : 1'b0;
      tick();
      if (fv_l) fv_count++;
      check_eq("b2b_fv", 32'(fv_l), 32'((c == 8) || (c == 17)));
      if (c == 8) begin
        check_eq("b2b_y_ff", 32'(y_l), 32'hFF);
`ifdef DEMUX_PARITY_EN
        check_eq("par_ff", 32'(par_l), 32'd0);
`endif
      end else if (c == 17) begin
        check_eq("b2b_y_00", 32'(y_l), 32'h00);
`ifdef DEMUX_PARITY_EN
        check_eq("par_00", 32'(par_l), 32'd0);
`endif
      end
    end
    din_valid = 1'b0;
    frame_ready = 1'b0;
    check_eq("b2b_count", 32'(fv_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
